// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate datapath.
// Used by the accumulation stage, its bus interface and its adder.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   localparam int PROD_W_DEF = 16;
   localparam int ACC_W_DEF  = 24;
   localparam int CNT_W_DEF  = 4;

endpackage

// File: rtl/product_accumulator_if.sv
// Command, product-input and result-output handshake bundle of product_accumulator.
// The slave modport is the accumulator's view; master is the driver/consumer view.
interface product_accumulator_if
   import mac_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);

   logic              start;
   logic [CNT_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] product;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              overflow;
   logic              busy;

   modport slave (
      input  start, len, in_valid, product, out_ready,
      output in_ready, out_valid, acc_out, overflow, busy
   );

   modport master (
      output start, len, in_valid, product, out_ready,
      input  in_ready, out_valid, acc_out, overflow, busy
   );

endinterface

// File: rtl/product_accumulator_adder.sv
// Combinational ACC_W+1-bit add of the accumulator and a zero-extended product.
// Overflow wraps modulo 2^ACC_W unless ACC_SATURATE_EN is defined, which clamps to all-ones.
module acc_adder #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 24
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] product,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] wide;

   assign wide  = {1'b0, acc} + (ACC_W+1)'(product);
   assign carry = wide[ACC_W];

`ifdef ACC_SATURATE_EN
   // A clamped accumulator re-overflows on any nonzero add, so it stays clamped.
   assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
   assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of multiplier products and hands the sum downstream.
// Saturating arithmetic is selected at build time with ACC_SATURATE_EN (see acc_adder).
module product_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   product_accumulator_if.slave bus
);

   acc_state_t       state_q;
   acc_state_t       state_d;
   logic [CNT_W-1:0] remaining;
   logic [ACC_W-1:0] acc;
   logic             overflow_q;
   logic [ACC_W-1:0] acc_sum;
   logic             acc_carry;
   logic             in_ready;
   logic             beat;
   logic             start_take;

   // Handshake outputs are pure decodes of the state register.
   assign in_ready   = (state_q == ACCUM);
   assign beat       = in_ready && bus.in_valid;
   assign start_take = (state_q == IDLE) && bus.start;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.acc_out   = acc;
   assign bus.overflow  = overflow_q;

   acc_adder #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_adder (
      .acc     (acc),
      .product (bus.product),
      .sum     (acc_sum),
      .carry   (acc_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : ACCUM;
         ACCUM:   if (beat && remaining == CNT_W'(1)) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         acc        <= '0;
         overflow_q <= 1'b0;
         remaining  <= '0;
      end else if (start_take) begin
         acc        <= '0;
         overflow_q <= 1'b0;
         remaining  <= bus.len;
      end else if (beat) begin
         acc        <= acc_sum;
         overflow_q <= overflow_q | acc_carry;
         remaining  <= remaining - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (ACC_W=16), table vectors plus random
// transactions checked against an arithmetic model; honours ACC_SATURATE_EN.
module tb_product_accumulator;

   localparam int PW = 16;
   localparam int AW = 16;
   localparam int CW = 4;

`ifdef ACC_SATURATE_EN
   localparam logic [15:0] OVF_A = 16'hFFFF;
   localparam logic [15:0] OVF_B = 16'hFFFF;
   localparam logic [15:0] OVF_C = 16'hFFFF;
`else
   localparam logic [15:0] OVF_A = 16'h0001;
   localparam logic [15:0] OVF_B = 16'h0000;
   localparam logic [15:0] OVF_C = 16'h0005;
`endif

   typedef struct {
      int               n;
      logic [3:0][15:0] p;
      int               gap_mode;
      int               hold;
      logic [15:0]      exp_acc;
      logic             exp_ovf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;
   logic [15:0] prods[$];
   vec_t vecs[7];

   product_accumulator_if #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) bus ();

   product_accumulator #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference: plain sum of the queued products, then wrap or clamp to 16 bits.
   task automatic model(output logic [15:0] acc, output logic ovf);
      int total = 0;
      foreach (prods[i]) total += int'(prods[i]);
      ovf = (total > 65535);
`ifdef ACC_SATURATE_EN
      acc = ovf ? 16'hFFFF : total[15:0];
`else
      acc = total[15:0];
`endif
   endtask

   task automatic run_txn(input int n, input int gap_mode, input int hold,
                          input logic [15:0] exp_acc, input logic exp_ovf, input string tag);
      check({tag, "_idle"}, bus.busy, 0);
      bus.start = 1'b1;
      bus.len   = CW'(n);
      tick();
      bus.start = 1'b0;
      bus.len   = CW'($urandom);
      check({tag, "_in_ready_lat"}, bus.in_ready, n != 0);
      check({tag, "_len0_valid"}, bus.out_valid, n == 0);
      check({tag, "_busy"}, bus.busy, 1);
      for (int i = 0; i < n; i++) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
            bus.product  = 16'($urandom_range(1, 65535));
            tick();
            check({tag, "_gap"}, {bus.in_ready, bus.out_valid}, 2'b10);
         end
         bus.in_valid = 1'b1;
         bus.product  = prods[i];
         tick();
         if (i < n - 1) check({tag, "_beat"}, {bus.in_ready, bus.out_valid}, 2'b10);
      end
      bus.in_valid = 1'b0;
      check({tag, "_out_valid"}, {bus.in_ready, bus.out_valid}, 2'b01);
      check({tag, "_acc"}, bus.acc_out, exp_acc);
      check({tag, "_ovf"}, bus.overflow, exp_ovf);
      for (int h = 0; h < hold; h++) begin
         bus.start    = 1'b1;
         bus.len      = CW'($urandom);
         bus.in_valid = 1'b1;
         bus.product  = 16'($urandom_range(1, 65535));
         tick();
         check({tag, "_hold_valid"}, bus.out_valid, 1);
         check({tag, "_hold_acc"}, bus.acc_out, exp_acc);
         check({tag, "_hold_ovf"}, bus.overflow, exp_ovf);
      end
      // Start coinciding with the DONE handoff must not be taken.
      bus.in_valid  = 1'b0;
      bus.start     = 1'b1;
      bus.len       = CW'(3);
      bus.out_ready = 1'b1;
      tick();
      check({tag, "_handoff"}, {bus.busy, bus.out_valid}, 2'b00);
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] m_acc;
      logic        m_ovf;
      n_checks = 0;
      n_err    = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.product   = '0;
      bus.out_ready = 1'b0;

      vecs[0] = '{n: 2, p: {16'h0, 16'h0, 16'd36, 16'd8}, gap_mode: 0, hold: 0, exp_acc: 16'd44, exp_ovf: 1'b0};
      vecs[1] = '{n: 3, p: {16'h0, 16'd3, 16'd2, 16'd1}, gap_mode: 1, hold: 2, exp_acc: 16'd6, exp_ovf: 1'b0};
      vecs[2] = '{n: 0, p: {16'h0, 16'h0, 16'h0, 16'h0}, gap_mode: 0, hold: 5, exp_acc: 16'd0, exp_ovf: 1'b0};
      vecs[3] = '{n: 2, p: {16'h0, 16'h0, 16'h0002, 16'hFFFF}, gap_mode: 0, hold: 1, exp_acc: OVF_A, exp_ovf: 1'b1};
      vecs[4] = '{n: 4, p: {16'h4000, 16'h4000, 16'h4000, 16'h4000}, gap_mode: 0, hold: 0, exp_acc: OVF_B, exp_ovf: 1'b1};
      vecs[5] = '{n: 3, p: {16'h0, 16'h0005, 16'h8000, 16'h8000}, gap_mode: 1, hold: 0, exp_acc: OVF_C, exp_ovf: 1'b1};
      vecs[6] = '{n: 1, p: {16'h0, 16'h0, 16'h0, 16'hFFFF}, gap_mode: 0, hold: 1, exp_acc: 16'hFFFF, exp_ovf: 1'b0};

      repeat (3) tick();
      check("rst_outputs", {bus.busy, bus.in_ready, bus.out_valid, bus.overflow}, 4'b0000);
      check("rst_acc", bus.acc_out, 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         prods.delete();
         for (int j = 0; j < vecs[v].n; j++) prods.push_back(vecs[v].p[j]);
         run_txn(vecs[v].n, vecs[v].gap_mode, vecs[v].hold, vecs[v].exp_acc, vecs[v].exp_ovf,
                 $sformatf("vec%0d", v));
      end

      // Start pulsed mid-ACCUM must not re-latch len.
      bus.start = 1'b1;
      bus.len   = CW'(3);
      tick();
      bus.len      = CW'(1);
      bus.in_valid = 1'b1;
      bus.product  = 16'd10;
      tick();
      check("accum_start_ign1", {bus.in_ready, bus.out_valid}, 2'b10);
      bus.start   = 1'b0;
      bus.product = 16'd20;
      tick();
      check("accum_start_ign2", {bus.in_ready, bus.out_valid}, 2'b10);
      bus.product = 16'd30;
      tick();
      bus.in_valid = 1'b0;
      check("accum_start_done", bus.out_valid, 1);
      check("accum_start_acc", bus.acc_out, 60);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // Reset after two beats with a nonzero, overflowed partial sum.
      bus.start = 1'b1;
      bus.len   = CW'(5);
      tick();
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.product  = 16'hFFFF;
      tick();
      bus.product = 16'h0002;
      tick();
      bus.in_valid = 1'b0;
      check("pre_rst_ovf", {bus.overflow, bus.in_ready}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {bus.busy, bus.in_ready, bus.out_valid, bus.overflow}, 4'b0000);
      check("mid_rst_acc", bus.acc_out, 0);
      tick();
      rst_n = 1'b1;
      tick();
      prods.delete();
      prods.push_back(16'd8);
      prods.push_back(16'd36);
      run_txn(2, 0, 0, 16'd44, 1'b0, "post_rst");

      for (int t = 0; t < 30; t++) begin
         int n;
         n = $urandom_range(0, 15);
         prods.delete();
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 3) == 0) prods.push_back(16'($urandom_range(16'hC000, 16'hFFFF)));
            else prods.push_back(16'($urandom_range(0, 4095)));
         end
         model(m_acc, m_ovf);
         run_txn(n, 2, $urandom_range(0, 3), m_acc, m_ovf, $sformatf("rnd%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage directly downstream of the 8x8 combinational `array_multiplier`. It consumes the 16-bit `product` over a valid/ready handshake and sums a programmed number of products into a wider accumulator. It then presents the sum over an output valid/ready handshake. Together with the multiplier it forms the team's multiply-accumulate (dot-product) datapath.

## Interface
- `PROD_W`, default 16: width of the incoming product. Matches the multiplier's `product`.
- `ACC_W`, default 24: accumulator and result width. Must be ≥ `PROD_W`.
- `CNT_W`, default 4: width of the term count. Allows 0..15 terms.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begins a new accumulation; sampled only in IDLE.
- `len`  in  CNT_W  number of products to accumulate; sampled with `start`.
- `in_valid`  in  1  `product` is valid.
- `in_ready`  out  1  block accepts a product this cycle.
- `product`  in  PROD_W  unsigned multiplier output.
- `out_valid`  out  1  `acc_out` holds a completed sum.
- `out_ready`  in  1  consumer takes the result.
- `acc_out`  out  ACC_W  accumulated sum.
- `overflow`  out  1  sticky flag: the current accumulation exceeded `ACC_W` bits.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **FSM states:** IDLE, ACCUM, DONE.
- **IDLE:**
  - `in_ready`=0, `out_valid`=0.
  - When `start`=1: clear the accumulator and `overflow`, and latch `len` into a `remaining` counter.
  - If `len`=0, go to DONE with `acc_out`=0. Otherwise go to ACCUM.
- **ACCUM:**
  - `in_ready`=1.
  - A beat is accepted when `in_valid` and `in_ready` are both high. On each beat:
    - acc ← acc + zero-extended `product`;
    - `remaining` decrements.
  - The beat that brings `remaining` to 0 moves the FSM to DONE.
- **DONE:**
  - `out_valid`=1, with `acc_out` held stable.
  - When `out_ready`=1, go to IDLE.
  - `start` is ignored while in DONE.
- `start` is ignored in ACCUM and in DONE. It never aborts an accumulation.
- **Arithmetic:**
  - Unsigned only.
  - The adder is `ACC_W`+1 bits wide. A carry out sets `overflow`, which stays set until the next accepted `start` or reset.
  - Default behaviour on overflow is modulo 2^`ACC_W` wrap-around.
- `product` is ignored whenever `in_ready`=0.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - state=IDLE;
  - `acc_out`=0, `overflow`=0, `out_valid`=0, `in_ready`=0, `busy`=0;
  - `remaining`=0.
- Reset mid-operation abandons the partial sum immediately. No result is produced.
- **Latency:**
  - `in_ready` rises in the cycle after the cycle that samples `start`.
  - `out_valid` rises in the cycle after the final beat is accepted.
  - With `len`=0, `out_valid` rises in the cycle after `start`.
- **Throughput:** one product per cycle while in ACCUM. The minimum cycles from `start` back to IDLE is `len`+2 when `out_ready` is held high.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- **Back-to-back operation:**
  - `start` asserted in the same cycle that DONE hands off is not seen, because the state is still DONE.
  - `start` is accepted in the next cycle, once the state is IDLE.

## Configuration
- `ACC_SATURATE_EN`:
  - When defined, an add that overflows clamps the accumulator to 2^`ACC_W`−1. It stays clamped for the rest of the accumulation, and `overflow` is set.
  - When undefined, the sum wraps modulo 2^`ACC_W` and `overflow` is still set.

## Structure
- Package `mac_pkg` holds:
  - the state enum `acc_state_t` (IDLE, ACCUM, DONE);
  - default width constants `PROD_W_DEF`=16, `ACC_W_DEF`=24, `CNT_W_DEF`=4.
- Sub-module `acc_adder` is the natural split. It is a combinational `ACC_W`+1-bit add of acc and zero-extended product, and returns the next acc plus a carry. The `ACC_SATURATE_EN` clamp is implemented inside it.
- The top level holds the FSM, the `remaining` counter, and the output registers.

## Test plan
- Reset mid-ACCUM after two beats → all outputs return to their reset values immediately. A new `start` then runs a clean accumulation.
- `start`, `len`=2; products 8 (4×2) then 36 (12×3), each with `in_valid` held high → `out_valid` rises one cycle after the second beat, with `acc_out`=44 and `overflow`=0.
- `len`=3 with gaps in `in_valid` and a `product` value present while `in_valid`=0 → only the 3 handshaked beats are summed. Products 1, 2, 3 give 6.
- `len`=0 → `out_valid` in the cycle after `start`, with `acc_out`=0. Holding `out_ready` low for 5 cycles keeps `acc_out` stable and `start` ignored.
- `len`=15, every product 0xFFFF (sum 983025 > 2^24−1? no), so set `ACC_W`=16 and use `len`=2 with 0xFFFF, 0x0002:
  - without the macro → `acc_out`=0x0001, `overflow`=1;
  - with `ACC_SATURATE_EN` → `acc_out`=0xFFFF, `overflow`=1.
- `start` pulsed during ACCUM and during DONE → ignored. `len` is not re-latched and `acc_out` is unchanged.
